// File: rtl/pcm_i2s_tx.sv
// pcm_i2s_tx
// Stereo PCM to Philips I2S transmitter, bus master. Left/right sample pairs
// are pushed on a one-cycle strobe into a small FIFO and serialised MSB first,
// 32 BCLK periods per frame, with LRCLK leading the data by one BCLK.
// BCLK and LRCLK are derived from clk by an internal divider.
//
// Parameters
//   CLK_DIV     BCLK half-period in clk cycles (>= 1)
//   DEPTH_LOG2  FIFO depth is 2**DEPTH_LOG2 pairs (>= 1)
//
// Ports
//   clk        system clock, all state changes on its rising edge
//   rst_n      asynchronous active-low reset
//   stb_in     push strobe for left/right
//   left/right signed 16-bit samples
//   full       FIFO holds DEPTH pairs
//   level      number of stored pairs
//   overflow   one-cycle pulse when a push is dropped
//   underrun   one-cycle pulse when a frame starts with the FIFO empty
//   i2s_bclk   bit clock
//   i2s_lrclk  word select, 0 = left, 1 = right
//   i2s_sdata  serial data, changes only on BCLK falling edges
module pcm_i2s_tx #(
  parameter int CLK_DIV    = 4,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stb_in,
  input  logic [15:0]           left,
  input  logic [15:0]           right,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  underrun,
  output logic                  i2s_bclk,
  output logic                  i2s_lrclk,
  output logic                  i2s_sdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]         DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  // Divider and frame state
  logic [CW-1:0]         div_q, div_d;
  logic                  bclk_q, bclk_d;
  logic [4:0]            slot_q, slot_d;
  logic                  lrclk_q, lrclk_d;
  logic                  sdata_q, sdata_d;
  logic [31:0]           shift_q, shift_d;

  // FIFO state
  logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]           mem [DEPTH];
  logic [31:0]           pop_word;

  logic                  overflow_q, overflow_d;
  logic                  underrun_q, underrun_d;

  logic                  div_tc;
  logic                  fall_evt;
  logic                  frame_start;
  logic                  empty;
  logic                  push_ok;
  logic                  push_drop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level     = wr_ptr_q - rd_ptr_q;
  assign full      = (level == LEVEL_FULL);
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign pop_word  = mem[rd_ptr_q[DEPTH_LOG2-1:0]];

  assign div_tc      = (div_q == DIV_LAST);
  assign fall_evt    = div_tc && bclk_q;
  // Slot counter resets to 31 so the first fall event after reset opens a frame.
  assign frame_start = fall_evt && (slot_q == 5'd31);

  // Full/empty are judged on the registered state, so a same-cycle pop
  // never rescues a push into a full FIFO.
  assign push_ok   = stb_in && !full;
  assign push_drop = stb_in && full;

  always_comb begin
    div_d      = div_q;
    bclk_d     = bclk_q;
    slot_d     = slot_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    shift_d    = shift_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = push_drop;
    underrun_d = 1'b0;

    if (div_tc) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
    end else begin
      div_d = div_q + 1'b1;
    end

    if (fall_evt) begin
      slot_d  = slot_q + 5'd1;
      // LRCLK switches one slot ahead of each channel's MSB.
      lrclk_d = (slot_d >= 5'd15) && (slot_d <= 5'd30);
      if (frame_start) begin
        if (empty) begin
          shift_d    = '0;
          underrun_d = 1'b1;
        end else begin
          shift_d  = pop_word;
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end else begin
        shift_d = {shift_q[30:0], 1'b0};
      end
      sdata_d = shift_d[31];
    end

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      bclk_q     <= 1'b0;
      slot_q     <= 5'd31;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      shift_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      bclk_q     <= bclk_d;
      slot_q     <= slot_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      shift_q    <= shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      underrun_q <= underrun_d;
    end
  end

  // Sample storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= {left, right};
    end
  end

  assign i2s_bclk  = bclk_q;
  assign i2s_lrclk = lrclk_q;
  assign i2s_sdata = sdata_q;
  assign overflow  = overflow_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_pcm_i2s_tx.sv
module tb_pcm_i2s_tx;

  localparam int DEPTH = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb_in = 1'b0;
  logic [15:0] left  = '0;
  logic [15:0] right = '0;
  logic        full, overflow, underrun, i2s_bclk, i2s_lrclk, i2s_sdata;
  logic [2:0]  level;

  logic        rst1_n = 1'b0;
  logic        stb1   = 1'b0;
  logic [15:0] left1  = '0;
  logic [15:0] right1 = '0;
  logic        full1, overflow1, underrun1, bclk1, lrclk1, sdata1;
  logic [2:0]  level1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rd_idx = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  pcm_i2s_tx #(.CLK_DIV(4), .DEPTH_LOG2(2)) dut (
    .clk(clk), .rst_n(rst_n), .stb_in(stb_in), .left(left), .right(right),
    .full(full), .level(level), .overflow(overflow), .underrun(underrun),
    .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata)
  );

  pcm_i2s_tx #(.CLK_DIV(1), .DEPTH_LOG2(2)) dut1 (
    .clk(clk), .rst_n(rst1_n), .stb_in(stb1), .left(left1), .right(right1),
    .full(full1), .level(level1), .overflow(overflow1), .underrun(underrun1),
    .i2s_bclk(bclk1), .i2s_lrclk(lrclk1), .i2s_sdata(sdata1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after edge e-1, so a drive now is sampled at edge e.
  task automatic goto_edge(input int e);
    while (cyc < e - 1) tick();
  endtask

  function automatic int model_level();
    return sb_q.size() - rd_idx;
  endfunction

  task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
    bit drop;
    drop   = (model_level() == DEPTH);
    stb_in = 1'b1;
    left   = l;
    right  = r;
    tick();
    stb_in = 1'b0;
    if (!drop) sb_q.push_back({l, r});
    $display("push L=%h R=%h edge=%0d dropped=%0d level=%0d", l, r, cyc, drop, level);
    check("overflow", {31'd0, overflow}, {31'd0, drop});
    check("level", {29'd0, level}, model_level());
    check("full", {31'd0, full}, {31'd0, model_level() == DEPTH});
  endtask

  // Bus monitor: decodes frames from BCLK edges and pops the scoreboard at
  // every frame start (empty scoreboard means a silent, underrun frame).
  task automatic monitor();
    int          ms = 31;
    bit          active = 1'b0;
    bit          exp_ur;
    logic [31:0] cur = '0;
    logic [31:0] shr = '0;
    forever begin
      @(posedge i2s_bclk or negedge i2s_bclk or negedge rst_n);
      if (!rst_n) begin
        ms     = 31;
        active = 1'b0;
        rd_idx = sb_q.size();
      end else if (i2s_bclk) begin
        check("lrclk", {31'd0, i2s_lrclk}, {31'd0, (ms >= 15) && (ms <= 30)});
        shr = {shr[30:0], i2s_sdata};
        if (ms == 31 && active) begin
          $display("frame data=%h expected=%h", shr, cur);
          check("frame", shr, cur);
          active = 1'b0;
        end
      end else begin
        ms = (ms + 1) % 32;
        if (ms == 0) begin
          exp_ur = (model_level() == 0);
          if (exp_ur) cur = '0;
          else begin
            cur = sb_q[rd_idx];
            rd_idx++;
          end
          active = 1'b1;
          #1;
          check("underrun_at_frame", {31'd0, underrun}, {31'd0, exp_ur});
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [31:0] pairs [7];
    time         t0;
    pairs[0] = 32'h1234_FEDC;
    pairs[1] = 32'h8000_7FFF;
    pairs[2] = 32'hFFFF_0001;
    pairs[3] = 32'h0F0F_F0F0;
    pairs[4] = 32'hDEAD_BEEF;
    pairs[5] = 32'h5555_AAAA;
    pairs[6] = 32'h0102_0304;

    fork
      monitor();
    join_none

    // Reset state
    #1;
    check("rst_bclk", {31'd0, i2s_bclk}, 32'd0);
    check("rst_lrclk", {31'd0, i2s_lrclk}, 32'd0);
    check("rst_sdata", {31'd0, i2s_sdata}, 32'd0);
    check("rst_level", {29'd0, level}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_udr", {31'd0, underrun}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Idle start-up: BCLK first rises at edge 4, first frame underruns at edge 8
    for (int e = 1; e <= 7; e++) begin
      tick();
      $display("idle edge=%0d bclk=%0d sdata=%0d underrun=%0d", cyc, i2s_bclk, i2s_sdata, underrun);
      check("idle_bclk", {31'd0, i2s_bclk}, {31'd0, e >= 4});
      check("idle_sdata", {31'd0, i2s_sdata}, 32'd0);
      check("idle_udr", {31'd0, underrun}, 32'd0);
    end
    tick();
    check("udr_edge8", {31'd0, underrun}, 32'd1);
    tick();
    check("udr_edge9", {31'd0, underrun}, 32'd0);

    // Single frame, popped at edge 264
    goto_edge(20);
    push_pair(16'h8001, 16'h7FFE);
    goto_edge(266);
    check("level_after_pop", {29'd0, level}, 32'd0);

    // Overflow: five back-to-back pushes into a depth-4 FIFO
    goto_edge(300);
    for (int i = 0; i < 5; i++) push_pair(pairs[i][31:16], pairs[i][15:0]);
    check("full_after_5", {31'd0, full}, 32'd1);
    check("level_after_5", {29'd0, level}, 32'd4);

    // Push into full FIFO on the frame-start edge: dropped, pop proceeds
    goto_edge(520);
    push_pair(pairs[5][31:16], pairs[5][15:0]);
    check("level_full_pop", {29'd0, level}, 32'd3);

    // Push into empty FIFO on the frame-start edge: underrun yet stored
    goto_edge(1544);
    push_pair(pairs[6][31:16], pairs[6][15:0]);
    check("level_empty_push", {29'd0, level}, 32'd1);

    // Reset at slot 20 with two pairs queued
    goto_edge(2060);
    push_pair(16'hCAFE, 16'hF00D);
    push_pair(16'h7777, 16'h8888);
    goto_edge(2219);
    #2;
    rst_n = 1'b0;
    #1;
    $display("mid-frame reset level=%0d bclk=%0d lrclk=%0d sdata=%0d", level, i2s_bclk, i2s_lrclk, i2s_sdata);
    check("mrst_level", {29'd0, level}, 32'd0);
    check("mrst_full", {31'd0, full}, 32'd0);
    check("mrst_bclk", {31'd0, i2s_bclk}, 32'd0);
    check("mrst_lrclk", {31'd0, i2s_lrclk}, 32'd0);
    check("mrst_sdata", {31'd0, i2s_sdata}, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    goto_edge(9);
    check("mrst_udr_edge8", {31'd0, underrun}, 32'd1);
    goto_edge(8 + 512 + 2);
    check("mrst_level_end", {29'd0, level}, 32'd0);

    // CLK_DIV=1 instance
    tick();
    rst1_n = 1'b1;
    stb1   = 1'b1;
    left1  = 16'hA5A5;
    right1 = 16'h5A5A;
    tick();
    stb1 = 1'b0;
    check("d1_level_push", {29'd0, level1}, 32'd1);
    @(negedge bclk1);
    t0 = $time;
    #1;
    check("d1_level_pop", {29'd0, level1}, 32'd0);
    check("d1_udr", {31'd0, underrun1}, 32'd0);
    w = '0;
    for (int k = 0; k < 32; k++) begin
      @(posedge bclk1);
      #1;
      w = {w[30:0], sdata1};
      check("d1_lrclk", {31'd0, lrclk1}, {31'd0, (k >= 15) && (k <= 30)});
    end
    $display("clkdiv1 frame data=%h expected=%h", w, 32'hA5A5_5A5A);
    check("d1_frame", w, 32'hA5A5_5A5A);
    @(negedge bclk1);
    check("d1_frame_len", 32'($time - t0), 32'd640);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
